// File: rtl/fifo_buf_pkg.sv
// Shared defaults and sizing helpers for the UART-side FIFO buffer.
// Depth is always a power of two derived from the pointer width.
package fifo_buf_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;
    localparam int CNT_W      = DEF_ADDR_W + 1;

    function automatic int depth_of(input int addr_w);
        return 32'sd1 <<< addr_w;
    endfunction

endpackage

// File: rtl/fifo_buf_ctrl.sv
// Pointer, occupancy and flag control for fifo_buf_interface.
// Full/empty are resolved from the occupancy count, never from pointer equality.
module fifo_buf_ctrl
    import fifo_buf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic              clr_ovr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              ovr
);

    localparam int              CNT_BITS = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH    = CNT_BITS'(depth_of(ADDR_W));

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_next;
    logic              rd_ok;
    logic              wr_ok;
    logic              drop;

    // Acceptance decisions and next occupancy
    always_comb begin
        rd_ok      = rd & ~empty;
        wr_ok      = wr & (~full | rd_ok);
        drop       = wr & ~wr_ok;
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + CNT_BITS'(1'b1);
        end else if (rd_ok && !wr_ok) begin
            count_next = count - CNT_BITS'(1'b1);
        end else begin
            count_next = count;
        end
    end

    assign wr_en   = wr_ok;
    assign wr_addr = wr_ptr;
    assign rd_addr = rd_ptr;

    // Pointer, count, flag and sticky overrun registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1'b1);
            if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1'b1);
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == DEPTH);
            // A dropped write wins over a simultaneous clear
            if (drop) begin
                ovr <= 1'b1;
            end else if (clr_ovr) begin
                ovr <= 1'b0;
            end else begin
                ovr <= ovr;
            end
        end
    end

endmodule

// File: rtl/fifo_buf_interface.sv
// First-word fall-through FIFO between the UART and the MIPS bus interface.
// Holds the storage array; dout is a pure read mux of the head entry.
module fifo_buf_interface
    import fifo_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] din,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              ovr
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    fifo_buf_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_ctrl (
        .clock   (clock),
        .reset   (reset),
        .wr      (wr),
        .rd      (rd),
        .clr_ovr (clr_ovr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovr     (ovr)
    );

    // Storage array; cleared on reset so an empty FIFO reads back zero
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= din;
        end
    end

    assign dout = mem[rd_addr];

endmodule

// File: tb/tb_fifo_buf_interface.sv
// Self-checking bench for fifo_buf_interface: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_fifo_buf_interface;
    import fifo_buf_pkg::*;

    localparam int DEPTH = depth_of(DEF_ADDR_W);

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  wr = 1'b0;
    logic                  rd = 1'b0;
    logic                  clr_ovr = 1'b0;
    logic [DEF_DATA_W-1:0] din = '0;
    logic [DEF_DATA_W-1:0] dout;
    logic                  empty;
    logic                  full;
    logic [CNT_W-1:0]      count;
    logic                  ovr;

    int checks = 0;
    int fails  = 0;

    logic [DEF_DATA_W-1:0] q[$];
    logic                  m_ovr = 1'b0;

    fifo_buf_interface dut (
        .clock   (clock),
        .reset   (reset),
        .wr      (wr),
        .rd      (rd),
        .din     (din),
        .clr_ovr (clr_ovr),
        .dout    (dout),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovr     (ovr)
    );

    always #5 clock = ~clock;

    // One clock cycle of stimulus; the model applies the queue rules at the same edge
    task automatic drive(input logic w, input logic r, input logic [7:0] d, input logic c);
        bit pop, push;
        wr = w; rd = r; din = d; clr_ovr = c;
        pop  = r && (q.size() > 0);
        push = w && ((q.size() < DEPTH) || pop);
        if (w && !push) m_ovr = 1'b1;
        else if (c)     m_ovr = 1'b0;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(d);
        @(posedge clock); #1;
        wr = 1'b0; rd = 1'b0; clr_ovr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q.delete();
        m_ovr = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (ovr !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %b want 0", ovr); end
        checks++; if (dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h want 00", dout); end
    endtask

    task automatic test_fill();
        logic [7:0] vals [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, vals[i], 1'b0);
            checks++; if (int'(count) !== i + 1) begin fails++; $display("FAIL fill_count: got %0d want %0d", count, i + 1); end
            checks++; if (dout !== 8'hA1) begin fails++; $display("FAIL fill_dout: got %h want a1", dout); end
            checks++; if (full !== (i == 3)) begin fails++; $display("FAIL fill_full: got %b want %b", full, (i == 3)); end
        end
    endtask

    task automatic test_overrun_drain();
        logic [7:0] vals [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        drive(1'b1, 1'b0, 8'hEE, 1'b0);
        checks++; if (ovr !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b want 1", ovr); end
        checks++; if (count !== 3'd4) begin fails++; $display("FAIL ovr_count: got %0d want 4", count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dout !== vals[i]) begin fails++; $display("FAIL drain_dout: got %h want %h", dout, vals[i]); end
            drive(1'b0, 1'b1, 8'h00, 1'b0);
        end
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL drain_empty: got %b want 1", empty); end
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        checks++; if (count !== 3'd0) begin fails++; $display("FAIL underflow_count: got %0d want 0", count); end
        checks++; if (ovr !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b want 1", ovr); end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (ovr !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", ovr); end
    endtask

    task automatic test_full_wr_rd();
        logic [7:0] vals [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, vals[i], 1'b0);
        drive(1'b1, 1'b1, 8'h55, 1'b0);
        checks++; if (count !== 3'd4) begin fails++; $display("FAIL fullrw_count: got %0d want 4", count); end
        checks++; if (dout !== 8'hB2) begin fails++; $display("FAIL fullrw_dout: got %h want b2", dout); end
        checks++; if (full !== 1'b1 || ovr !== 1'b0) begin fails++; $display("FAIL fullrw_flags: got full=%b ovr=%b want full=1 ovr=0", full, ovr); end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'h00, 1'b0);
        checks++; if (dout !== 8'h55 || count !== 3'd1) begin fails++; $display("FAIL fullrw_last: got dout=%h count=%0d want 55 1", dout, count); end
        drive(1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    task automatic test_empty_wr_rd();
        drive(1'b1, 1'b1, 8'h77, 1'b0);
        checks++; if (count !== 3'd1) begin fails++; $display("FAIL emptyrw_count: got %0d want 1", count); end
        checks++; if (empty !== 1'b0) begin fails++; $display("FAIL emptyrw_empty: got %b want 0", empty); end
        checks++; if (dout !== 8'h77) begin fails++; $display("FAIL emptyrw_dout: got %h want 77", dout); end
        drive(1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    task automatic test_wrap();
        logic [7:0] next_in = 8'h10;
        logic [7:0] next_out = 8'h10;
        for (int it = 0; it < 10; it++) begin
            for (int k = 0; k < 3; k++) begin
                drive(1'b1, 1'b0, next_in, 1'b0);
                next_in = next_in + 8'd1;
            end
            for (int k = 0; k < 3; k++) begin
                checks++; if (dout !== next_out) begin fails++; $display("FAIL wrap_order: got %h want %h", dout, next_out); end
                next_out = next_out + 8'd1;
                drive(1'b0, 1'b1, 8'h00, 1'b0);
            end
            checks++; if (count !== 3'd0) begin fails++; $display("FAIL wrap_count: got %0d want 0", count); end
        end
        drive(1'b1, 1'b0, 8'h99, 1'b0);
        drive(1'b1, 1'b0, 8'h9A, 1'b0);
        checks++; if (count !== 3'd2) begin fails++; $display("FAIL midreset_pre: got %0d want 2", count); end
        do_reset();
        checks++; if (count !== 3'd0 || empty !== 1'b1) begin fails++; $display("FAIL midreset_state: got count=%0d empty=%b want 0 1", count, empty); end
        checks++; if (dout !== 8'h00) begin fails++; $display("FAIL midreset_dout: got %h want 00", dout); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit w, r, c;
            w = ((i / 50) % 2 == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            r = ((i / 50) % 2 == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 19) == 0);
            drive(w, r, 8'($urandom), c);
            checks++;
            if (int'(count) !== q.size() || empty !== (q.size() == 0) ||
                full !== (q.size() == DEPTH) || ovr !== m_ovr) begin
                fails++;
                $display("FAIL rand_state: got count=%0d empty=%b full=%b ovr=%b want count=%0d ovr=%b",
                         count, empty, full, ovr, q.size(), m_ovr);
            end
            if (q.size() > 0) begin
                checks++; if (dout !== q[0]) begin fails++; $display("FAIL rand_dout: got %h want %h", dout, q[0]); end
            end
        end
    endtask

    initial begin
        @(posedge clock); #1;
        test_reset();
        test_fill();
        test_overrun_drain();
        test_full_wr_rd();
        test_empty_wr_rd();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/fifo_buf_interface.md
Name: fifo_buf_interface

Overview:
Parametrised multi-entry successor to the single-register flag buffer, placed between the UART receiver/transmitter and the MIPS-side bus interface. It accepts words on a write strobe and presents the oldest word on dout (first-word fall-through), with registered empty/full, an occupancy count and a sticky overrun flag. It removes the byte-loss that occurs with a one-deep buffer when the consumer is slow.

Parameters:
DATA_W, 8, width of each stored word
ADDR_W, 2, pointer width; depth = 2**ADDR_W (default 4 entries); legal range 1..8

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
wr  input  1  write strobe; pushes din when accepted (replaces set_flag)
rd  input  1  read/acknowledge strobe; pops head entry when accepted (replaces clr_flag)
din  input  DATA_W  write data
clr_ovr  input  1  clears sticky overrun flag
dout  output  DATA_W  head-of-queue word (fall-through)
empty  output  1  1 = no valid entries (inverse of old flag)
full  output  1  1 = occupancy equals depth
count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W
ovr  output  1  sticky: a write was dropped while full

Behaviour:
- Reset (clock edge with reset=1): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, ovr=0, all storage entries=0, so dout=0. Reset overrides all other inputs in that cycle; in-flight data is discarded.
- Storage: 2**ADDR_W x DATA_W register array. dout = mem[rd_ptr] combinationally. When empty, dout shows the entry at rd_ptr: stale data, or 0 after reset. Consumers must qualify dout with !empty.
- Accepted write: wr=1 and (full=0 or rd accepted in the same cycle). Effect: mem[wr_ptr]<=din, wr_ptr<=wr_ptr+1 (wraps modulo depth).
- Accepted read: rd=1 and empty=0. Effect: rd_ptr<=rd_ptr+1 (wraps). Data is visible on dout the cycle after the write edge, so latency = 1 clock.
- Count update:
  - +1 on write only
  - -1 on read only
  - unchanged on both or neither
- Flags: empty and full are registered, derived from next count: empty = (count_next==0), full = (count_next==2**ADDR_W).
- Simultaneous wr+rd:
  - When full: both are accepted. The head is popped and the new word is written into the freed slot. count stays at depth, full stays 1, ovr is not set.
  - When empty: the read is ignored and the write is accepted. count goes 0->1 and empty goes to 0 next cycle. The new word is not bypassed to dout in the same cycle.
- Write while full without rd: din is dropped, pointers and count are unchanged, ovr<=1.
- Read while empty: no effect; no underflow, pointers unchanged.
- ovr is sticky until clr_ovr=1. If clr_ovr and a new dropping write occur in the same cycle, set wins (ovr=1).
- Pointer wrap: wr_ptr/rd_ptr are plain ADDR_W-bit counters. Full vs empty is resolved by count, not by pointer equality.
- No combinational path from rd/wr to empty/full/count. The only combinational output path is rd_ptr/mem -> dout.

Decomposition:
- Package fifo_buf_pkg:
  - default DATA_W/ADDR_W localparams
  - function depth_of(ADDR_W) returning 2**ADDR_W
  - count-width localparam CNT_W = ADDR_W+1
- One sub-module, fifo_buf_ctrl: pointer/count/flag logic, outputs wr_en, wr_addr, rd_addr, empty, full, count, ovr. The top holds the register array and the dout mux.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, ovr=0, dout=0x00.
- Write 0xA1,0xB2,0xC3,0xD4 on consecutive cycles (DATA_W=8, ADDR_W=2) -> count 1,2,3,4; full=1 after 4th edge; dout=0xA1 throughout.
- From full, wr=1 din=0xEE without rd -> ovr=1, count=4. Then 4 reads -> dout sequence 0xA1,0xB2,0xC3,0xD4, then empty=1. Apply clr_ovr=1 -> ovr=0.
- From full, wr+rd same cycle with din=0x55 -> count stays 4, dout=0xB2. After 3 more reads, dout=0x55 is the last entry.
- Empty, wr+rd same cycle with din=0x77 -> count=1, empty=0 next cycle, dout=0x77.
- Push 3 / pop 3 repeatedly for 10 iterations (pointers wrap) with an incrementing data pattern -> output order matches input, count returns to 0. Then assert reset mid-sequence with count=2 -> count=0, empty=1, dout=0x00 next cycle.
